keypad_press_emulator: RTL and testbench
========================================

KEYPAD_PRESS_EMULATOR -- requirements
Module: keypad_press_emulator

Interface
REQ-001 SHALL have parameters: FIFO_DEPTH, default 4, command queue depth (power of 2, 2..16); BOUNCE_CYCLES, default 1000, bounce window length; BOUNCE_STEP, default 50, cycles between bounce toggles; GAP_CYCLES, default 2000, released time after each press.
REQ-002 SHALL have ports, clock and reset first: clk in 1, system clock; rst in 1, reset.
REQ-003 SHALL use one clock (clk) and an asynchronous, active-low reset (rst).
REQ-004 SHALL have ports: cmd_valid in 1, command offered; cmd_key in 4, key index 0..11; cmd_hold in 16, contact-closed cycles; cmd_ready out 1, slot free.
REQ-005 SHALL have ports: out_to_keypad in 4, scanner row drive, one-hot active-high; in_from_keypad out 3, column sense to scanner, active-high.
REQ-006 SHALL have ports: busy out 1, press in progress; done out 1, one-cycle pulse per completed press; key_err out 1, sticky bad-key flag; fifo_count out 5, queued commands.

Function
REQ-007 SHALL accept a command when cmd_valid and cmd_ready are high in the same cycle.
REQ-008 SHALL drive cmd_ready high iff fifo_count < FIFO_DEPTH.
REQ-009 SHALL drop a command with cmd_key > 11 without queuing it, set key_err, and hold key_err until reset.
REQ-010 SHALL, on simultaneous push and pop, leave fifo_count unchanged and preserve order.
REQ-011 SHALL implement FSM states IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP.
REQ-012 SHALL, in IDLE with fifo_count > 0, pop the head command, latch key and hold, and enter BOUNCE_IN on the next cycle.
REQ-013 SHALL stay BOUNCE_CYCLES cycles in BOUNCE_IN, then HOLD.
REQ-014 SHALL stay max(cmd_hold,1) cycles in HOLD, then BOUNCE_OUT.
REQ-015 SHALL stay BOUNCE_CYCLES cycles in BOUNCE_OUT, then GAP.
REQ-016 SHALL stay GAP_CYCLES cycles in GAP, pulse done in the last GAP cycle, then return to IDLE.
REQ-017 SHALL hold contact at 1 in HOLD and at 0 in IDLE and GAP.
REQ-018 SHALL, in bounce states, set contact to bit 0 of an 8-bit maximal LFSR (seed 8'hA5 at reset), advancing it every BOUNCE_STEP cycles.
REQ-019 SHALL drive in_from_keypad[c] = contact AND out_to_keypad[key/3] AND (key%3 == c).
REQ-020 SHALL treat in_from_keypad as combinational from out_to_keypad, so the scanner sees the response in the same cycle it drives a row.
REQ-021 SHALL drive all in_from_keypad bits to 0 when out_to_keypad is not one-hot.
REQ-022 SHALL drive busy high in every state except IDLE.
REQ-023 SHALL size all counters at 32 bits, with no wrap inside any state.

Reset
REQ-024 SHALL, while rst is low, force: FSM to IDLE, FIFO empty, fifo_count 0, contact 0, in_from_keypad 0, busy 0, done 0, key_err 0, cmd_ready 1.
REQ-025 SHALL abort any press in progress on reset assertion, with release taking effect immediately and no done pulse.
REQ-026 SHALL resume FIFO acceptance on the first clk edge after rst deasserts.

Configuration
REQ-027 SHALL provide macro KEYPAD_PRESS_EMULATOR_BOUNCE_EN.
REQ-028 SHALL, with KEYPAD_PRESS_EMULATOR_BOUNCE_EN defined, implement bounce states per REQ-013, REQ-015 and REQ-018.
REQ-029 SHALL, without KEYPAD_PRESS_EMULATOR_BOUNCE_EN, omit the LFSR, skip bounce states (IDLE->HOLD, HOLD->GAP) and give clean edges, with all other behaviour unchanged.

Verification
REQ-030 SHALL pass, macro off: push key 4, hold 100, scanner driving row 1 -> in_from_keypad = 3'b010 for exactly 100 cycles; done pulses GAP_CYCLES later.
REQ-031 SHALL pass: push key 12 -> key_err=1, fifo_count stays 0, no press generated.
REQ-032 SHALL pass, FIFO_DEPTH=4: push 5 commands back-to-back -> cmd_ready low after the 4th; 5th not accepted until first pop; presses appear in push order.
REQ-033 SHALL pass, macro on: key 0, hold 10 -> sense bit 0 toggles during both 1000-cycle bounce windows, steady 1 for 10 cycles, 0 thereafter.
REQ-034 SHALL pass: assert rst mid-HOLD -> in_from_keypad=0 immediately, FIFO empty, no done; next command processed normally.
REQ-035 SHALL pass: out_to_keypad = 4'b0011 during HOLD -> in_from_keypad = 3'b000.

Source files
------------

// File: rtl/keypad_press_emulator.sv
// keypad_press_emulator: replays queued key presses onto a 4x3 matrix keypad
// interface. The scanner drives one row at a time and reads column sense back
// combinationally. Each press runs IDLE -> BOUNCE_IN -> HOLD -> BOUNCE_OUT -> GAP.
// Optional contact bounce is enabled with KEYPAD_PRESS_EMULATOR_BOUNCE_EN. When
// it is undefined the bounce states are skipped and the contact edges are clean.
module keypad_press_emulator #(
  parameter int FIFO_DEPTH    = 4,
  parameter int BOUNCE_CYCLES = 1000,
  parameter int BOUNCE_STEP   = 50,
  parameter int GAP_CYCLES    = 2000
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [3:0]  cmd_key,
  input  logic [15:0] cmd_hold,
  output logic        cmd_ready,
  input  logic [3:0]  out_to_keypad,
  output logic [2:0]  in_from_keypad,
  output logic        busy,
  output logic        done,
  output logic        key_err,
  output logic [4:0]  fifo_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [31:0] GAP_LEN = 32'((GAP_CYCLES < 1) ? 1 : GAP_CYCLES);

  typedef struct packed {
    logic [3:0]  key;
    logic [15:0] hold;
  } cmd_t;

  typedef enum logic [2:0] {IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP} state_t;

  cmd_t          fifo_mem [FIFO_DEPTH];
  cmd_t          cur;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, bad_key;
  state_t        state, state_n;
  logic [31:0]   cnt, hold_len;
  logic          contact, bounce_bit;
  logic [1:0]    row, col;
  logic [3:0]    base;

  assign cmd_ready = (fifo_count < 5'(FIFO_DEPTH));
  assign bad_key   = cmd_valid && cmd_ready && (cmd_key > 4'd11);
  assign push      = cmd_valid && cmd_ready && (cmd_key <= 4'd11);
  assign pop       = (state == IDLE) && (fifo_count != 5'd0);
  assign busy      = (state != IDLE);
  assign hold_len  = (cur.hold == 16'd0) ? 32'd1 : {16'd0, cur.hold};

  // Command storage; contents need no reset, validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_key, cmd_hold};
  end

  // Queue pointers, occupancy and the sticky bad-key flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      key_err    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 5'd1;
        2'b01:   fifo_count <= fifo_count - 5'd1;
        default: fifo_count <= fifo_count;
      endcase
      if (bad_key) key_err <= 1'b1;
    end
  end

  // Latch the head command as it leaves the queue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     cur <= '0;
    else if (pop) cur <= fifo_mem[rd_ptr];
  end

`ifdef KEYPAD_PRESS_EMULATOR_BOUNCE_EN
  localparam logic [31:0] BNC_LEN  = 32'((BOUNCE_CYCLES < 1) ? 1 : BOUNCE_CYCLES);
  localparam logic [31:0] STEP_LEN = 32'((BOUNCE_STEP < 1) ? 1 : BOUNCE_STEP);
  logic [7:0]  lfsr;
  logic [31:0] step_cnt;
  logic        in_bounce;

  assign in_bounce  = (state == BOUNCE_IN) || (state == BOUNCE_OUT);
  assign bounce_bit = lfsr[0];

  // x^8+x^6+x^5+x^4+1 LFSR, stepped only while bouncing; it keeps its state
  // between windows so successive presses bounce differently
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr     <= 8'hA5;
      step_cnt <= '0;
    end else if (in_bounce) begin
      if (step_cnt == STEP_LEN - 32'd1) begin
        step_cnt <= '0;
        lfsr     <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end else begin
        step_cnt <= step_cnt + 32'd1;
      end
    end else begin
      step_cnt <= '0;
    end
  end
`else
  localparam logic [31:0] BNC_LEN = 32'd1;
  assign bounce_bit = 1'b0;
`endif

  // State register and per-state cycle counter (cleared on every transition)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (state_n != state)   cnt <= '0;
      else if (state != IDLE) cnt <= cnt + 32'd1;
    end
  end

  // Next state, contact level and done strobe
  always_comb begin
    state_n = state;
    contact = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
`ifdef KEYPAD_PRESS_EMULATOR_BOUNCE_EN
        if (fifo_count != 5'd0) state_n = BOUNCE_IN;
`else
        if (fifo_count != 5'd0) state_n = HOLD;
`endif
      end
      BOUNCE_IN: begin
        contact = bounce_bit;
        if (cnt == BNC_LEN - 32'd1) state_n = HOLD;
      end
      HOLD: begin
        contact = 1'b1;
`ifdef KEYPAD_PRESS_EMULATOR_BOUNCE_EN
        if (cnt == hold_len - 32'd1) state_n = BOUNCE_OUT;
`else
        if (cnt == hold_len - 32'd1) state_n = GAP;
`endif
      end
      BOUNCE_OUT: begin
        contact = bounce_bit;
        if (cnt == BNC_LEN - 32'd1) state_n = GAP;
      end
      GAP: begin
        if (cnt == GAP_LEN - 32'd1) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Key index to matrix position: row = key/3, col = key%3
  always_comb begin
    row  = (cur.key >= 4'd9) ? 2'd3 :
           (cur.key >= 4'd6) ? 2'd2 :
           (cur.key >= 4'd3) ? 2'd1 : 2'd0;
    base = {2'b00, row} + {1'b0, row, 1'b0};
    col  = 2'(cur.key - base);
  end

  // Column sense is purely combinational from the row drive; a non-one-hot
  // row pattern never produces a response
  for (genvar c = 0; c < 3; c++) begin : g_col
    assign in_from_keypad[c] = rst && contact && $onehot(out_to_keypad) &&
                               out_to_keypad[row] && (col == 2'(c));
  end

endmodule

// File: tb/tb_keypad_press_emulator.sv
// Directed bench for keypad_press_emulator with a press scoreboard. Expected
// presses are queued as commands are accepted. The row driven to the DUT
// follows the head of that queue, and each done pulse retires one entry.
module tb_keypad_press_emulator;
  localparam int FD = 4, BC = 40, BS = 3, GC = 30;

  logic        clk, rst, cmd_valid, cmd_ready, busy, done, key_err;
  logic [3:0]  cmd_key, out_to_keypad;
  logic [15:0] cmd_hold;
  logic [2:0]  in_from_keypad;
  logic [4:0]  fifo_count;

  typedef struct {
    logic [3:0]  key;
    logic [15:0] hold;
  } exp_t;

  exp_t       sb[$];
  int         checks, errors, cyc, done_cnt, hold_seen, bad_seen, last_hi;
  logic [1:0] cur_row;
  logic       force_en;
  logic [3:0] force_val;

  keypad_press_emulator #(.FIFO_DEPTH(FD), .BOUNCE_CYCLES(BC), .BOUNCE_STEP(BS),
                          .GAP_CYCLES(GC)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_key(cmd_key),
    .cmd_hold(cmd_hold), .cmd_ready(cmd_ready), .out_to_keypad(out_to_keypad),
    .in_from_keypad(in_from_keypad), .busy(busy), .done(done),
    .key_err(key_err), .fifo_count(fifo_count));

  assign out_to_keypad = force_en ? force_val : (4'b0001 << cur_row);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] col_oh(input logic [3:0] k);
    return 3'b001 << (k % 4'd3);
  endfunction

  function automatic logic [1:0] row_of(input logic [3:0] k);
    return 2'(k / 4'd3);
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    int   exp_len;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        hold_seen = 0;
        bad_seen  = 0;
      end else begin
        if (in_from_keypad != 3'b000) begin
          last_hi = cyc;
          if (sb.size() > 0 && in_from_keypad == col_oh(sb[0].key)) hold_seen++;
          else bad_seen++;
        end
        if (done) begin
          done_cnt++;
          if (sb.size() == 0) check("done_unexpected", sb.size(), 1);
          else begin
            e = sb.pop_front();
            exp_len = (e.hold == 16'd0) ? 1 : int'(e.hold);
`ifdef KEYPAD_PRESS_EMULATOR_BOUNCE_EN
            check("hold_min", (hold_seen >= exp_len) ? 1 : 0, 1);
`else
            check("hold_len", hold_seen, exp_len);
            check("gap_len", cyc - last_hi, GC);
`endif
            check("wrong_sense", bad_seen, 0);
          end
          hold_seen = 0;
          bad_seen  = 0;
        end
      end
      cur_row = (sb.size() > 0) ? row_of(sb[0].key) : 2'd0;
    end
  endtask

  task automatic push(input logic [3:0] k, input logic [15:0] h);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_key = k; cmd_hold = h;
    while (!cmd_ready && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) check("push_timeout", n, 0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    if (k <= 4'd11) sb.push_back('{k, h});
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while ((busy || fifo_count != 5'd0) && n < max) begin @(negedge clk); n++; end
    if (n >= max) check("idle_timeout", n, 0);
  endtask

  task automatic wait_sense(input int max);
    int n;
    n = 0;
    while (in_from_keypad == 3'b000 && n < max) begin @(negedge clk); n++; end
    if (n >= max) check("sense_timeout", n, 0);
  endtask

  initial begin
    int d0, n, tog, ok;
    logic prev;
    rst = 1'b0; cmd_valid = 1'b0; cmd_key = '0; cmd_hold = '0;
    force_en = 1'b0; force_val = '0; cur_row = '0;
    checks = 0; errors = 0; cyc = 0; done_cnt = 0;
    hold_seen = 0; bad_seen = 0; last_hi = 0;
    fork monitor(); join_none

    // Reset values
    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_key_err", int'(key_err), 0);
    check("rst_count", int'(fifo_count), 0);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_sense", int'(in_from_keypad), 0);
    @(negedge clk); rst = 1'b1;

    // Single press: key 4, hold 100, row 1 driven -> 3'b010 while held
    push(4'd4, 16'd100);
    wait_idle(1000);
    check("a_done_cnt", done_cnt, 1);

    // Bad key is dropped and flagged
    push(4'd12, 16'd5);
    @(negedge clk);
    check("b_key_err", int'(key_err), 1);
    check("b_count", int'(fifo_count), 0);
    repeat (10) @(negedge clk);
    check("b_busy", int'(busy), 0);
    check("b_done_cnt", done_cnt, 1);

    // Fill the queue behind a long press; fifth waits for the first pop
    push(4'd0, 16'd200);
    n = 0;
    while (!busy && n < 20) begin @(negedge clk); n++; end
    check("c_busy", int'(busy), 1);
    push(4'd1, 16'd3);
    push(4'd3, 16'd1);
    push(4'd8, 16'd0);
    push(4'd11, 16'd7);
    @(negedge clk);
    check("c_full_ready", int'(cmd_ready), 0);
    check("c_full_count", int'(fifo_count), 4);
    d0 = done_cnt;
    push(4'd6, 16'd2);
    check("c_fifth_after_pop", (done_cnt > d0) ? 1 : 0, 1);
    wait_idle(5000);
    check("c_done_cnt", done_cnt, 7);
    check("c_key_err_sticky", int'(key_err), 1);

    // Non-one-hot row drive during HOLD gives no sense
    push(4'd7, 16'd40);
    wait_sense(500);
`ifdef KEYPAD_PRESS_EMULATOR_BOUNCE_EN
    repeat (BC) @(negedge clk);
`endif
    repeat (5) @(negedge clk);
    #1 force_en = 1'b1; force_val = 4'b0011;
    #1 check("d_two_rows", int'(in_from_keypad), 0);
    force_val = 4'b0000;
    #1 check("d_no_row", int'(in_from_keypad), 0);
    force_val = 4'b0100;
    #1 check("d_right_row", int'(in_from_keypad), 2);
    force_val = 4'b0001;
    #1 check("d_wrong_row", int'(in_from_keypad), 0);
    force_en = 1'b0;
    wait_idle(1000);
    check("d_done_cnt", done_cnt, 8);

    // Reset mid-HOLD aborts the press and flushes the queue
    push(4'd5, 16'd50);
    push(4'd9, 16'd10);
    push(4'd2, 16'd3);
    wait_sense(500);
`ifdef KEYPAD_PRESS_EMULATOR_BOUNCE_EN
    repeat (BC) @(negedge clk);
`endif
    repeat (10) @(negedge clk);
    check("e_pre_count", int'(fifo_count), 2);
    #2 rst = 1'b0;
    sb.delete();
    #1;
    check("e_sense", int'(in_from_keypad), 0);
    check("e_busy", int'(busy), 0);
    check("e_count", int'(fifo_count), 0);
    check("e_done", int'(done), 0);
    check("e_ready", int'(cmd_ready), 1);
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (GC + 2 * BC + 60) @(negedge clk);
    check("e_no_done", done_cnt, d0);
    check("e_idle", int'(busy), 0);
    push(4'd10, 16'd4);
    wait_idle(1000);
    check("e_next_press", done_cnt, d0 + 1);

`ifdef KEYPAD_PRESS_EMULATOR_BOUNCE_EN
    // Bounce windows toggle, hold is steady, release is clean
    push(4'd0, 16'd10);
    n = 0;
    while (!busy && n < 20) begin @(negedge clk); n++; end
    prev = in_from_keypad[0]; tog = 0;
    for (int i = 0; i < BC; i++) begin
      if (in_from_keypad[0] != prev) tog++;
      prev = in_from_keypad[0];
      @(negedge clk);
    end
    check("f_bounce_in_toggles", (tog > 0) ? 1 : 0, 1);
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      if (in_from_keypad == 3'b001) ok++;
      @(negedge clk);
    end
    check("f_hold_steady", ok, 10);
    prev = 1'b1; tog = 0;
    for (int i = 0; i < BC; i++) begin
      if (in_from_keypad[0] != prev) tog++;
      prev = in_from_keypad[0];
      @(negedge clk);
    end
    check("f_bounce_out_toggles", (tog > 0) ? 1 : 0, 1);
    ok = 0;
    for (int i = 0; i < GC - 1; i++) begin
      if (in_from_keypad == 3'b000) ok++;
      @(negedge clk);
    end
    check("f_gap_clean", ok, GC - 1);
    wait_idle(500);
`endif

    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
